xy_waypoint_sequencer: RTL and testbench

Upstream command stage for the XY positioning controller. It buffers a short queue of BCD X/Y waypoints and drives the controller's 8-bit target bus and MOTION input one waypoint at a time. It watches the returned 8-bit position bus to detect arrival, then advances to the next waypoint. It also reports arrival, completion, and error events.

---
 rtl/xy_waypoint_sequencer_if.sv | 19 +
 rtl/xy_waypoint_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_xy_waypoint_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xy_waypoint_sequencer_if.sv
// Ready/valid waypoint handshake between the command source and the sequencer.
// Each word carries one BCD waypoint: [7:4]=X, [3:0]=Y.
interface xy_waypoint_sequencer_if;
    logic [7:0] wp_data;
    logic       wp_valid;
    logic       wp_ready;

    modport master (
        output wp_data,
        output wp_valid,
        input  wp_ready
    );

    modport slave (
        input  wp_data,
        input  wp_valid,
        output wp_ready
    );
endinterface

// File: rtl/xy_waypoint_sequencer.sv
// Queues BCD X/Y waypoints and steps the XY controller through them one at a time,
// detecting arrival from the returned position bus and flagging BCD and timeout errors.
module xy_waypoint_sequencer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MIN_MOVE = 4,
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    xy_waypoint_sequencer_if.slave       wp,
    input  logic                         i_run,
    input  logic                         i_abort,
    input  logic [7:0]                   i_pos,
    output logic [7:0]                   o_target,
    output logic                         o_motion,
    output logic                         o_busy,
    output logic                         o_arrived,
    output logic                         o_done,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_bcd_err,
    output logic                         o_timeout_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned MV_W  = 8;
    localparam int unsigned ST_W  = $clog2(SETTLE + 1);

    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
    localparam logic [MV_W-1:0]  MIN_MOVE_C  = MV_W'(MIN_MOVE);
    localparam logic [MV_W-1:0]  TO_LAST_C   = MV_W'(TIMEOUT - 1);
    localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MOVE,
        S_ARRIVE
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;

    logic [7:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [MV_W-1:0]    r_mv_cnt;
    logic [ST_W-1:0]    r_settle;
    logic [7:0]         r_target;
    logic               r_motion;
    logic               r_busy;
    logic               r_arrived;
    logic               r_done;
    logic               r_bcd_err;
    logic               r_timeout_err;

    logic               w_push;
    logic               w_bcd_ok;
    logic               w_store;
    logic               w_pop;
    logic               w_flush;
    logic               w_timeout;
    logic               w_chk_en;
    logic               w_match;
    logic [MV_W-1:0]    w_mv_cnt_nx;
    logic [ST_W-1:0]    w_settle_nx;
    logic [CNT_W-1:0]   w_count_nx;
    logic [PTR_W-1:0]   w_rd_nx;
    logic [PTR_W-1:0]   w_wr_nx;
    logic [PTR_W-1:0]   w_wr_addr;
    logic [PTR_W-1:0]   w_rd_plus;
    logic [7:0]         w_head_nx;

    assign wp.wp_ready = (r_count < DEPTH_C) & ~i_abort;

    assign w_push    = wp.wp_valid & wp.wp_ready;
    assign w_bcd_ok  = (wp.wp_data[7:4] <= 4'd9) && (wp.wp_data[3:0] <= 4'd9);
    assign w_store   = w_push & w_bcd_ok;
    assign w_chk_en  = (r_mv_cnt >= MIN_MOVE_C);
    assign w_match   = (i_pos == r_target);
    assign w_rd_plus = r_rd_ptr + PTR_W'(1);
    // When leaving ARRIVE straight into LOAD the head is the entry behind the one being popped.
    assign w_head_nx = w_pop ? r_mem[w_rd_plus] : r_mem[r_rd_ptr];

    // Next-state and per-cycle control decisions.
    always_comb begin
        w_state_nx  = r_state;
        w_mv_cnt_nx = '0;
        w_settle_nx = '0;
        w_pop       = 1'b0;
        w_flush     = 1'b0;
        w_timeout   = 1'b0;
        if (i_abort) begin
            w_state_nx = S_IDLE;
            w_flush    = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_run && (r_count != '0)) begin
                        w_state_nx = S_LOAD;
                    end
                end
                S_LOAD: begin
                    w_state_nx = S_MOVE;
                end
                S_MOVE: begin
                    w_mv_cnt_nx = r_mv_cnt + MV_W'(1);
                    if (w_chk_en && w_match) begin
                        w_settle_nx = r_settle + ST_W'(1);
                    end
                    if (w_chk_en && w_match && (r_settle == SETTLE_LAST)) begin
                        w_state_nx = S_ARRIVE;
                    end else if (r_mv_cnt == TO_LAST_C) begin
                        w_state_nx = S_IDLE;
                        w_timeout  = 1'b1;
                        w_flush    = 1'b1;
                    end
                end
                S_ARRIVE: begin
                    w_pop = 1'b1;
                    if (i_run && (r_count > CNT_W'(1))) begin
                        w_state_nx = S_LOAD;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointer/occupancy update; a flush still keeps a word accepted in the same cycle.
    always_comb begin
        w_count_nx = r_count;
        w_rd_nx    = r_rd_ptr;
        w_wr_nx    = r_wr_ptr;
        w_wr_addr  = r_wr_ptr;
        if (w_flush) begin
            w_rd_nx    = '0;
            w_wr_addr  = '0;
            w_wr_nx    = w_store ? PTR_W'(1) : '0;
            w_count_nx = w_store ? CNT_W'(1) : '0;
        end else begin
            if (w_store) begin
                w_wr_nx = r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                w_rd_nx = w_rd_plus;
            end
            unique case ({w_store, w_pop})
                2'b10:   w_count_nx = r_count + CNT_W'(1);
                2'b01:   w_count_nx = r_count - CNT_W'(1);
                default: w_count_nx = r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[w_wr_addr] <= wp.wp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Datapath and registered outputs, all derived from the next-state decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_mv_cnt      <= '0;
            r_settle      <= '0;
            r_target      <= 8'h00;
            r_motion      <= 1'b0;
            r_busy        <= 1'b0;
            r_arrived     <= 1'b0;
            r_done        <= 1'b0;
            r_bcd_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_rd_ptr      <= w_rd_nx;
            r_wr_ptr      <= w_wr_nx;
            r_count       <= w_count_nx;
            r_mv_cnt      <= (w_state_nx == S_MOVE) ? w_mv_cnt_nx : '0;
            r_settle      <= w_settle_nx;
            if (w_state_nx == S_LOAD) begin
                r_target <= w_head_nx;
            end
            r_motion      <= (w_state_nx == S_MOVE);
            r_busy        <= (w_state_nx != S_IDLE);
            r_arrived     <= (w_state_nx == S_ARRIVE);
            r_done        <= (w_state_nx == S_ARRIVE) && (w_count_nx == CNT_W'(1));
            r_bcd_err     <= r_bcd_err | (w_push & ~w_bcd_ok);
            r_timeout_err <= r_timeout_err | w_timeout;
        end
    end

    assign o_target      = r_target;
    assign o_motion      = r_motion;
    assign o_busy        = r_busy;
    assign o_arrived     = r_arrived;
    assign o_done        = r_done;
    assign o_count       = r_count;
    assign o_bcd_err     = r_bcd_err;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_xy_waypoint_sequencer.sv
// Directed bench for xy_waypoint_sequencer with a simple position model that
// steps each BCD axis one digit per cycle toward the target while MOTION is high.
module tb_xy_waypoint_sequencer;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       run      = 1'b0;
    logic       abort    = 1'b0;
    logic [7:0] pos      = 8'h00;
    logic       model_en = 1'b1;

    logic [7:0] target;
    logic       motion;
    logic       busy;
    logic       arrived;
    logic       done;
    logic [2:0] count;
    logic       bcd_err;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    xy_waypoint_sequencer_if wp ();

    xy_waypoint_sequencer #(
        .DEPTH   (4),
        .MIN_MOVE(4),
        .SETTLE  (2),
        .TIMEOUT (255)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wp           (wp),
        .i_run        (run),
        .i_abort      (abort),
        .i_pos        (pos),
        .o_target     (target),
        .o_motion     (motion),
        .o_busy       (busy),
        .o_arrived    (arrived),
        .o_done       (done),
        .o_count      (count),
        .o_bcd_err    (bcd_err),
        .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] step_digit(input logic [3:0] p, input logic [3:0] t);
        if (p < t) return p + 4'd1;
        if (p > t) return p - 4'd1;
        return p;
    endfunction

    always @(negedge clk) begin
        if (model_en && motion) begin
            pos = {step_digit(pos[7:4], target[7:4]), step_digit(pos[3:0], target[3:0])};
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        wp.wp_data  = d;
        wp.wp_valid = 1'b1;
        @(negedge clk);
        wp.wp_valid = 1'b0;
    endtask

    task automatic wait_motion(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = motion;
        end
        check(tag, 32'(seen), 1);
    endtask

    task automatic wait_arrived(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = arrived;
        end
        check(tag, 32'(seen), 1);
    endtask

    initial begin
        logic [7:0] exp_tgt [5];
        logic [7:0] got_tgt [5];
        logic       got_done [5];
        int t_tgt, t_mot, t_arr, n_arr, n_done, mot_cycles;
        bit mot_at_arr, pp;

        exp_tgt[0] = 8'h12; exp_tgt[1] = 8'h34; exp_tgt[2] = 8'h56;
        exp_tgt[3] = 8'h78; exp_tgt[4] = 8'h90;
        wp.wp_data  = 8'h00;
        wp.wp_valid = 1'b0;

        // Power-on reset and idle state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready",   32'(wp.wp_ready), 1);
        check("rst_target",  32'(target), 32'h00);
        check("rst_motion",  32'(motion), 0);
        check("rst_busy",    32'(busy), 0);
        check("rst_count",   32'(count), 0);
        check("rst_bcd",     32'(bcd_err), 0);
        check("rst_timeout", 32'(timeout_err), 0);

        // Dirty the state, then reset asynchronously mid-cycle
        push(8'hA2);
        push(8'h12);
        check("pre_rst_count", 32'(count), 1);
        check("pre_rst_bcd",   32'(bcd_err), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count",  32'(count), 0);
        check("arst_bcd",    32'(bcd_err), 0);
        check("arst_target", 32'(target), 32'h00);
        check("arst_motion", 32'(motion), 0);
        check("arst_ready",  32'(wp.wp_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single move 00 -> 35 with exact cycle timing
        push(8'h35);
        run = 1'b1;
        t_tgt = -1; t_mot = -1; t_arr = -1; n_arr = 0; n_done = 0; mot_at_arr = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (t_tgt < 0 && target == 8'h35) t_tgt = c;
            if (t_mot < 0 && motion) t_mot = c;
            if (arrived) begin
                n_arr++;
                t_arr = c;
                mot_at_arr = motion;
            end
            if (done) n_done++;
        end
        run = 1'b0;
        check("single_tgt_cycle", 32'(t_tgt), 1);
        check("single_mot_cycle", 32'(t_mot), 2);
        check("single_arr_cycle", 32'(t_arr), 8);
        check("single_arr_count", 32'(n_arr), 1);
        check("single_done_count", 32'(n_done), 1);
        check("single_mot_in_arrive", 32'(mot_at_arr), 0);
        check("single_end_motion", 32'(motion), 0);
        check("single_end_count",  32'(count), 0);
        check("single_end_busy",   32'(busy), 0);

        // Full queue, plus a push landing on the same edge as a pop
        push(8'h12); push(8'h34); push(8'h56); push(8'h78);
        check("q_full_count", 32'(count), 4);
        check("q_full_ready", 32'(wp.wp_ready), 0);
        run = 1'b1;
        n_arr = 0; pp = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (pp) begin
                check("q_pushpop_count", 32'(count), 3);
                wp.wp_valid = 1'b0;
                pp = 1'b0;
            end
            if (arrived && n_arr < 5) begin
                got_tgt[n_arr]  = target;
                got_done[n_arr] = done;
                n_arr++;
                if (n_arr == 2) begin
                    wp.wp_data  = 8'h90;
                    wp.wp_valid = 1'b1;
                    pp = 1'b1;
                end
            end
            if (n_arr == 5 && !busy) break;
        end
        run = 1'b0;
        check("q_arrivals", 32'(n_arr), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("q_target%0d", i), 32'(got_tgt[i]), 32'(exp_tgt[i]));
            check($sformatf("q_done%0d", i), 32'(got_done[i]), (i == 4) ? 1 : 0);
        end
        check("q_end_count", 32'(count), 0);

        // BCD reject: only the valid word is stored and executed
        check("bcd_pre", 32'(bcd_err), 0);
        push(8'hA2);
        check("bcd_set", 32'(bcd_err), 1);
        check("bcd_not_stored", 32'(count), 0);
        push(8'h29);
        check("bcd_valid_stored", 32'(count), 1);
        run = 1'b1;
        wait_arrived("bcd_arrive_wait");
        check("bcd_arr_target", 32'(target), 32'h29);
        check("bcd_arr_done", 32'(done), 1);
        @(negedge clk);
        run = 1'b0;
        check("bcd_end_count", 32'(count), 0);

        // Timeout with the position frozen away from the target
        model_en = 1'b0;
        push(8'h55);
        push(8'h66);
        check("to_pre_count", 32'(count), 2);
        run = 1'b1;
        mot_cycles = 0; n_arr = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (motion) mot_cycles++;
            if (arrived) n_arr++;
            if (mot_cycles > 0 && !motion) break;
        end
        run = 1'b0;
        check("to_move_cycles", 32'(mot_cycles), 255);
        check("to_flag", 32'(timeout_err), 1);
        check("to_motion", 32'(motion), 0);
        check("to_flushed", 32'(count), 0);
        check("to_busy", 32'(busy), 0);
        check("to_no_arrive", 32'(n_arr), 0);
        check("to_bcd_sticky", 32'(bcd_err), 1);
        model_en = 1'b1;

        // Abort during the first move
        push(8'h11); push(8'h22); push(8'h33);
        check("ab_pre_count", 32'(count), 3);
        run = 1'b1;
        wait_motion("ab_motion_wait");
        abort = 1'b1;
        #1;
        check("ab_ready_low", 32'(wp.wp_ready), 0);
        @(negedge clk);
        check("ab_motion", 32'(motion), 0);
        check("ab_count", 32'(count), 0);
        check("ab_busy", 32'(busy), 0);
        check("ab_no_arrive", 32'(arrived), 0);
        check("ab_no_done", 32'(done), 0);
        check("ab_target_hold", 32'(target), 32'h11);
        check("ab_to_sticky", 32'(timeout_err), 1);
        abort = 1'b0;
        run = 1'b0;
        @(negedge clk);
        check("ab_idle", 32'(busy), 0);

        // run dropped during the first move: finish it, keep the rest
        push(8'h44); push(8'h55); push(8'h66);
        run = 1'b1;
        wait_motion("rd_motion_wait");
        run = 1'b0;
        wait_arrived("rd_arrive_wait");
        check("rd_arr_target", 32'(target), 32'h44);
        check("rd_arr_done", 32'(done), 0);
        @(negedge clk);
        check("rd_busy", 32'(busy), 0);
        check("rd_count", 32'(count), 2);
        check("rd_motion", 32'(motion), 0);
        @(negedge clk);
        check("rd_stays_idle", 32'(busy), 0);
        check("rd_target_hold", 32'(target), 32'h44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
